// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO filled over valid/ready,
// drained by a serializer that sends frames back-to-back.
module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 26,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       fifo_empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             push, pop;

    // Storage carries no reset: stale entries are unreachable once pointers clear.
    assign push = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // The line value for the next bit is registered on the edge that enters it.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx_ready   = (count_q != FULL_CNT);
        fifo_empty = (count_q == '0);
        tx_busy    = (state_q != IDLE);
        uart_tx    = tx_q;
    end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level line decoder plus a timing model of
// when each accepted byte must start on the line.
module tb_uart_tx_buffered;
    localparam int CPB   = 26;
    localparam int CPB2  = 2;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
    logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
    logic       tx_ready, uart_tx, tx_busy, fifo_empty;
    logic       tx_ready2, uart_tx2, tx_busy2, fifo_empty2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .uart_tx(uart_tx2), .tx_busy(tx_busy2), .fifo_empty(fifo_empty2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line level at offset 'off' clocks into one 8N1 frame of byte b.
    function automatic logic exp_line(input logic [7:0] b, input int off, input int cpb);
        int k;
        k = off / cpb;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Line decoder: mid-bit sampling, records byte and start-edge cycle.
    logic [7:0] rx_b0[$], rx_b1[$];
    int         rx_s0[$], rx_s1[$];
    int         mon_err[2];
    bit         mact[2];
    int         mst[2];
    logic [7:0] mbyte[2];

    always @(negedge clk) begin
        logic line;
        int   cpb;
        int   off;
        for (int m = 0; m < 2; m++) begin
            line = (m == 0) ? uart_tx : uart_tx2;
            cpb  = (m == 0) ? CPB : CPB2;
            if (!reset_n) begin
                mact[m] = 1'b0;
            end else if (!mact[m]) begin
                if (line === 1'b0) begin
                    mact[m] = 1'b1;
                    mst[m]  = cyc;
                end
            end else begin
                off = cyc - mst[m];
                if (off % cpb == cpb / 2) begin
                    if (off / cpb == 0) begin
                        if (line !== 1'b0) mon_err[m]++;
                    end else if (off / cpb <= 8) begin
                        mbyte[m][off/cpb-1] = line;
                    end else begin
                        if (line !== 1'b1) mon_err[m]++;
                        if (m == 0) begin
                            rx_b0.push_back(mbyte[0]);
                            rx_s0.push_back(mst[0]);
                        end else begin
                            rx_b1.push_back(mbyte[1]);
                            rx_s1.push_back(mst[1]);
                        end
                        mact[m] = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model: each accepted byte starts at max(accept+1, previous start + 10 bits).
    logic [7:0] stim[$];
    logic [7:0] exp_b[$];
    int         exp_s[$];

    function automatic int starts_le(input int c);
        int n = 0;
        foreach (exp_s[i]) if (exp_s[i] <= c) n++;
        return n;
    endfunction

    function automatic bit busy_at(input int c);
        foreach (exp_s[i]) if (c >= exp_s[i] && c < exp_s[i] + 10 * CPB) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run1(input int gap_pct, input string name, output int acc_at_drop);
        int idx = 0;
        int t0;
        int occ;
        int last;
        int limit;
        int st;
        bit hold = 1'b0;
        bit seen_drop = 1'b0;
        t0 = cyc;
        limit = stim.size() * 12 * CPB + 500;
        exp_b.delete(); exp_s.delete(); rx_b0.delete(); rx_s0.delete();
        mon_err[0] = 0;
        acc_at_drop = -1;
        forever begin
            occ  = exp_b.size() - starts_le(cyc);
            last = (exp_s.size() > 0) ? exp_s[$] : -100000;
            chk($sformatf("%s_ready@%0d", name, cyc), tx_ready, occ < DEPTH);
            chk($sformatf("%s_empty@%0d", name, cyc), fifo_empty, occ == 0);
            chk($sformatf("%s_busy@%0d", name, cyc), tx_busy, busy_at(cyc));
            if (tx_ready === 1'b0 && !seen_drop) begin
                seen_drop = 1'b1;
                acc_at_drop = exp_b.size();
            end
            if (idx >= stim.size() && cyc >= last + 10 * CPB + 2) break;
            if (cyc - t0 > limit) begin
                chk({name, "_timeout_cycles"}, cyc - t0, limit);
                break;
            end
            if (!hold) begin
                tx_valid = 1'b0;
                if (idx < stim.size() && $urandom_range(99) >= gap_pct) begin
                    tx_valid = 1'b1;
                    tx_data  = stim[idx];
                    hold     = 1'b1;
                end
            end
            if (hold && occ < DEPTH) begin
                st = (cyc + 2 > last + 10 * CPB) ? cyc + 2 : last + 10 * CPB;
                exp_b.push_back(tx_data);
                exp_s.push_back(st);
                idx++;
                hold = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk({name, "_rx_count"}, rx_b0.size(), exp_b.size());
        for (int i = 0; i < rx_b0.size() && i < exp_b.size(); i++) begin
            chk($sformatf("%s_rx_byte%0d", name, i), rx_b0[i], exp_b[i]);
            chk($sformatf("%s_rx_start%0d", name, i), rx_s0[i], exp_s[i]);
        end
        chk({name, "_frame_err"}, mon_err[0], 0);
    endtask

    initial begin
        int k;
        int lows;
        int nonempty;
        int drop;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_tx2", uart_tx2, 1'b1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        reset_n = 1'b0;
        #1;
        chk("idle_rst_tx", uart_tx, 1'b1);
        chk("idle_rst_ready", tx_ready, 1'b1);
        chk("idle_rst_busy", tx_busy, 1'b0);
        chk("idle_rst_empty", fifo_empty, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte 0x21: exact waveform, busy fall 260 clocks after start edge.
        chk("sb_ready", tx_ready, 1'b1);
        tx_data = 8'h21;
        tx_valid = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("sb_line_at_k", uart_tx, 1'b1);
        chk("sb_empty_at_k", fifo_empty, 1'b0);
        for (int off = 0; off <= 260; off++) begin
            @(negedge clk);
            if (off < 260) chk($sformatf("sb_line%0d", off), uart_tx, exp_line(8'h21, off, CPB));
            else           chk("sb_line_after", uart_tx, 1'b1);
            chk($sformatf("sb_busy%0d", off), tx_busy, off < 260);
        end

        // Minimum divider: 0xFF then 0x00 back-to-back on the CPB=2 instance.
        rx_b1.delete(); rx_s1.delete();
        mon_err[1] = 0;
        chk("md_ready", tx_ready2, 1'b1);
        tx_data2 = 8'hFF;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_data2 = 8'h00;
        @(negedge clk);
        tx_valid2 = 1'b0;
        for (int off = 0; off <= 40; off++) begin
            if (off > 0) @(negedge clk);
            if (off < 20)      chk($sformatf("md_line%0d", off), uart_tx2, exp_line(8'hFF, off, CPB2));
            else if (off < 40) chk($sformatf("md_line%0d", off), uart_tx2, exp_line(8'h00, off - 20, CPB2));
            else               chk("md_line_after", uart_tx2, 1'b1);
        end
        chk("md_busy_after", tx_busy2, 1'b0);
        chk("md_rx_count", rx_b1.size(), 2);
        if (rx_b1.size() == 2) begin
            chk("md_rx0", rx_b1[0], 8'hFF);
            chk("md_rx1", rx_b1[1], 8'h00);
            chk("md_gap", rx_s1[1] - rx_s1[0], 20);
        end
        chk("md_frame_err", mon_err[1], 0);

        // Reset during data bit 3 of the first of three queued frames.
        @(negedge clk);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        tx_data = 8'hAA;
        @(negedge clk);
        tx_data = 8'h0F;
        @(negedge clk);
        tx_valid = 1'b0;
        while (cyc < k + 1 + 4 * CPB + 10) @(negedge clk);
        chk("mf_bit3_before_rst", uart_tx, 1'b0);
        chk("mf_pending_before_rst", fifo_empty, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mf_rst_tx", uart_tx, 1'b1);
        chk("mf_rst_busy", tx_busy, 1'b0);
        chk("mf_rst_empty", fifo_empty, 1'b1);
        chk("mf_rst_ready", tx_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        nonempty = 0;
        for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (fifo_empty !== 1'b1) nonempty++;
        end
        chk("mf_idle_low_cycles", lows, 0);
        chk("mf_nonempty_cycles", nonempty, 0);

        // Overflow / back-pressure with 0x00..0x09 held valid.
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back(8'(i));
        run1(0, "ovf", drop);
        chk("ovf_accepts_before_full", drop, DEPTH + 1);
        if (rx_s0.size() == 10) chk("ovf_span", rx_s0[9] + 10 * CPB - rx_s0[0], 100 * CPB);

        // Loopback byte sequence.
        stim.delete();
        stim.push_back(8'h21); stim.push_back(8'h20);
        stim.push_back(8'h30); stim.push_back(8'h40);
        run1(0, "lb", drop);

        // Randomized bytes with random producer gaps.
        stim.delete();
        for (int i = 0; i < 30; i++) stim.push_back(8'($urandom_range(255)));
        run1(60, "rnd", drop);
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back(8'($urandom_range(255)));
        run1(5, "rnd_dense", drop);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
